// File: rtl/zelda_pkg.sv
// rtl/zelda_pkg.sv - shared screen geometry, ROM layout and draw state types
// Contents: SCREEN_W/SCREEN_H map size, SPRITE edge length, LINK_BASE/ENEMY_BASE
// graphics ROM offsets, TRANSPARENT sprite colour key, draw_state_t FSM states,
// draw_job_t record of which request is being serviced.
package zelda_pkg;

  localparam int          SCREEN_W    = 320;
  localparam int          SCREEN_H    = 240;
  localparam int          SPRITE      = 16;
  localparam logic [16:0] LINK_BASE   = 17'd76800;
  localparam logic [16:0] ENEMY_BASE  = 17'd77056;
  localparam logic [8:0]  TRANSPARENT = 9'h1FF;

  typedef enum logic [2:0] {
    S_WAIT,
    S_IDLE_CNT,
    S_MAP,
    S_LINK,
    S_ENEMY,
    S_DRAIN,
    S_DONE
  } draw_state_t;

  typedef enum logic [1:0] {
    JOB_MAP,
    JOB_LINK,
    JOB_ENEMY
  } draw_job_t;

endpackage

// File: rtl/frame_timer.sv
// rtl/frame_timer.sv - idle frame counter producing one tick per frame period
// Ports: clock, reset (async, active-high); enable counts one cycle per clock;
// clear zeroes the count; tick pulses in the last counted cycle.
module frame_timer #(
  parameter int TICKS = 833333
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int          CW     = $clog2(TICKS + 1);
  // The cycle in which the request is sampled and the S_DONE cycle both belong
  // to the frame, so the tick fires two counts early.
  localparam int          LAST_I = (TICKS > 2) ? TICKS - 2 : 0;
  localparam logic [CW-1:0] LAST = CW'(LAST_I);

  logic [CW-1:0] count;

  assign tick = enable && (count == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/draw_datapath.sv
// rtl/draw_datapath.sv - map/sprite blitter from graphics ROM to VGA adapter
// Ports: clock, reset (async, active-high); idle/draw_map/draw_link/draw_enemies
// requests; link_x/link_y, enemy_x/enemy_y sprite origins; rom_addr/rom_data
// synchronous ROM port; vga_x/vga_y/vga_colour/vga_plot pixel writes;
// idle_done/draw_map_done/draw_link_done/draw_enemies_done one-cycle pulses.
// Build option: TRANSPARENCY_EN suppresses sprite pixels keyed TRANSPARENT.
module draw_datapath #(
  parameter int SCREEN_W    = zelda_pkg::SCREEN_W,
  parameter int SCREEN_H    = zelda_pkg::SCREEN_H,
  parameter int SPRITE      = zelda_pkg::SPRITE,
  parameter int FRAME_TICKS = 833333
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        idle,
  input  logic        draw_map,
  input  logic        draw_link,
  input  logic        draw_enemies,
  input  logic [8:0]  link_x,
  input  logic [7:0]  link_y,
  input  logic [8:0]  enemy_x,
  input  logic [7:0]  enemy_y,
  output logic [16:0] rom_addr,
  input  logic [8:0]  rom_data,
  output logic [8:0]  vga_x,
  output logic [7:0]  vga_y,
  output logic [8:0]  vga_colour,
  output logic        vga_plot,
  output logic        idle_done,
  output logic        draw_map_done,
  output logic        draw_link_done,
  output logic        draw_enemies_done
);
  import zelda_pkg::*;

  draw_state_t state;
  draw_job_t   job;
  logic [16:0] addr;
  logic [8:0]  col, col_last;
  logic [7:0]  row, row_last;
  logic [8:0]  org_x;
  logic [7:0]  org_y;
  logic [8:0]  px_x;
  logic [7:0]  px_y;
  logic        px_plot;
  logic [9:0]  scr_x;
  logic [8:0]  scr_y;
  logic        on_screen, scanning, scan_end, hide;
  logic        timer_en, timer_tick;

  assign scanning  = (state == S_MAP) || (state == S_LINK) || (state == S_ENEMY);
  assign scan_end  = (col == col_last) && (row == row_last);
  // Extra sum bit keeps sprites hanging off the right/bottom edge from wrapping.
  assign scr_x     = {1'b0, org_x} + {1'b0, col};
  assign scr_y     = {1'b0, org_y} + {1'b0, row};
  assign on_screen = (scr_x < 10'(SCREEN_W)) && (scr_y < 9'(SCREEN_H));
  assign rom_addr  = scanning ? addr : '0;
  assign timer_en  = (state == S_IDLE_CNT) && idle;

  frame_timer #(.TICKS(FRAME_TICKS)) u_frame_timer (
    .clock  (clock),
    .reset  (reset),
    .enable (timer_en),
    .clear  (!timer_en),
    .tick   (timer_tick)
  );

  // Colour arrives from the ROM in the plot cycle, so the colour key and the
  // colour itself are applied combinationally to the registered plot strobe.
`ifdef TRANSPARENCY_EN
  logic px_sprite;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) px_sprite <= 1'b0;
    else       px_sprite <= (state == S_LINK) || (state == S_ENEMY);
  end
  assign hide = px_sprite && (rom_data == TRANSPARENT);
`else
  assign hide = 1'b0;
`endif

  assign vga_plot   = px_plot && !hide;
  assign vga_colour = vga_plot ? rom_data : '0;
  assign vga_x      = px_x;
  assign vga_y      = px_y;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= S_WAIT;
      job               <= JOB_MAP;
      addr              <= '0;
      col               <= '0;
      row               <= '0;
      col_last          <= '0;
      row_last          <= '0;
      org_x             <= '0;
      org_y             <= '0;
      px_x              <= '0;
      px_y              <= '0;
      px_plot           <= 1'b0;
      idle_done         <= 1'b0;
      draw_map_done     <= 1'b0;
      draw_link_done    <= 1'b0;
      draw_enemies_done <= 1'b0;
    end else begin
      px_plot           <= scanning && on_screen;
      px_x              <= scr_x[8:0];
      px_y              <= scr_y[7:0];
      idle_done         <= 1'b0;
      draw_map_done     <= 1'b0;
      draw_link_done    <= 1'b0;
      draw_enemies_done <= 1'b0;

      case (state)
        S_WAIT: begin
          col <= '0;
          row <= '0;
          if (draw_map) begin
            state    <= S_MAP;
            job      <= JOB_MAP;
            addr     <= '0;
            org_x    <= '0;
            org_y    <= '0;
            col_last <= 9'(SCREEN_W - 1);
            row_last <= 8'(SCREEN_H - 1);
          end else if (draw_link) begin
            state    <= S_LINK;
            job      <= JOB_LINK;
            addr     <= LINK_BASE;
            org_x    <= link_x;
            org_y    <= link_y;
            col_last <= 9'(SPRITE - 1);
            row_last <= 8'(SPRITE - 1);
          end else if (draw_enemies) begin
            state    <= S_ENEMY;
            job      <= JOB_ENEMY;
            addr     <= ENEMY_BASE;
            org_x    <= enemy_x;
            org_y    <= enemy_y;
            col_last <= 9'(SPRITE - 1);
            row_last <= 8'(SPRITE - 1);
          end else if (idle) begin
            state <= S_IDLE_CNT;
          end
        end

        S_IDLE_CNT: begin
          if (!idle) begin
            state <= S_WAIT;
          end else if (timer_tick) begin
            state     <= S_DONE;
            idle_done <= 1'b1;
          end
        end

        S_MAP, S_LINK, S_ENEMY: begin
          // Raster order makes the ROM address a plain running count.
          addr <= addr + 17'd1;
          if (col == col_last) begin
            col <= '0;
            row <= row + 8'd1;
          end else begin
            col <= col + 9'd1;
          end
          if (scan_end) state <= S_DRAIN;
        end

        S_DRAIN: begin
          state <= S_DONE;
          case (job)
            JOB_MAP:   draw_map_done     <= 1'b1;
            JOB_LINK:  draw_link_done    <= 1'b1;
            default:   draw_enemies_done <= 1'b1;
          endcase
        end

        default: state <= S_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_datapath.sv
// tb/tb_draw_datapath.sv - randomized self-checking bench for draw_datapath
module tb_draw_datapath;

  localparam int J_MAP   = 0;
  localparam int J_LINK  = 1;
  localparam int J_ENEMY = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        idle = 1'b0, draw_map = 1'b0, draw_link = 1'b0, draw_enemies = 1'b0;
  logic [8:0]  link_x = '0, enemy_x = '0;
  logic [7:0]  link_y = '0, enemy_y = '0;
  logic [16:0] rom_addr;
  logic [8:0]  rom_data = '0;
  logic [8:0]  vga_x, vga_colour;
  logic [7:0]  vga_y;
  logic        vga_plot;
  logic        idle_done, draw_map_done, draw_link_done, draw_enemies_done;

  int n_checks = 0;
  int n_fail   = 0;
  bit enemy_sparse = 1'b0;

  typedef struct {
    int cyc;
    int x;
    int y;
    int col;
  } plot_t;
  plot_t exp_q[$];

  draw_datapath #(.FRAME_TICKS(10)) dut (
    .clock             (clock),
    .reset             (reset),
    .idle              (idle),
    .draw_map          (draw_map),
    .draw_link         (draw_link),
    .draw_enemies      (draw_enemies),
    .link_x            (link_x),
    .link_y            (link_y),
    .enemy_x           (enemy_x),
    .enemy_y           (enemy_y),
    .rom_addr          (rom_addr),
    .rom_data          (rom_data),
    .vga_x             (vga_x),
    .vga_y             (vga_y),
    .vga_colour        (vga_colour),
    .vga_plot          (vga_plot),
    .idle_done         (idle_done),
    .draw_map_done     (draw_map_done),
    .draw_link_done    (draw_link_done),
    .draw_enemies_done (draw_enemies_done)
  );

  always #5 clock = ~clock;

  function automatic logic [8:0] rom_word(input int a);
    logic [31:0] av;
    av = a;
    if (enemy_sparse && a >= 77056 && a < 77312)
      return (a == 77056 + 3 * 16 + 5) ? 9'h007 : 9'h1FF;
    return av[8:0];
  endfunction

  always @(posedge clock) rom_data <= rom_word(int'(rom_addr));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] dones();
    return {idle_done, draw_map_done, draw_link_done, draw_enemies_done};
  endfunction

  function automatic logic [63:0] all_outputs();
    return {rom_addr, vga_x, vga_y, vga_colour, vga_plot, dones()};
  endfunction

  // Expected pixel stream straight from the screen/sprite rules.
  task automatic build_expect(input int job, input int ox, input int oy, output int done_cyc);
    int w, h, base, a, x, y, c;
    bit vis;
    exp_q.delete();
    if (job == J_MAP) begin
      w = 320; h = 240; base = 0; ox = 0; oy = 0;
    end else begin
      w = 16; h = 16; base = (job == J_LINK) ? 76800 : 77056;
    end
    for (int r = 0; r < h; r++) begin
      for (int k = 0; k < w; k++) begin
        a = base + r * w + k;
        c = int'(rom_word(a));
        x = ox + k;
        y = oy + r;
        vis = (x < 320) && (y < 240);
`ifdef TRANSPARENCY_EN
        if (job != J_MAP && c == 'h1FF) vis = 1'b0;
`endif
        if (vis) exp_q.push_back('{r * w + k + 2, x, y, c});
      end
    end
    done_cyc = w * h + 2;
  endtask

  function automatic logic [63:0] pack_obs(input int n);
    return {6'd0, 32'(n), vga_x, vga_y, vga_colour};
  endfunction

  function automatic logic [63:0] pack_exp(input plot_t e);
    return {6'd0, 32'(e.cyc), 9'(e.x), 8'(e.y), 9'(e.col)};
  endfunction

  task automatic run_draw(input string tag, input int job, input int ox, input int oy);
    int done_cyc, n_plots, exp_plots, done_seen, done_at;
    logic [3:0] own;
    plot_t e;
    build_expect(job, ox, oy, done_cyc);
    exp_plots = exp_q.size();
    own = (job == J_MAP) ? 4'b0100 : (job == J_LINK) ? 4'b0010 : 4'b0001;
    @(negedge clock);
    link_x = 9'(ox); link_y = 8'(oy); enemy_x = 9'(ox); enemy_y = 8'(oy);
    if (job == J_MAP) begin
      draw_map = 1'b1;
      idle = 1'b1;
    end
    if (job == J_LINK) draw_link = 1'b1;
    if (job == J_ENEMY) draw_enemies = 1'b1;
    @(posedge clock);
    n_plots = 0; done_seen = 0; done_at = -1;
    for (int n = 1; n <= done_cyc + 3; n++) begin
      @(negedge clock);
      if (n == 1) begin
        draw_map = 1'b0; draw_link = 1'b0; draw_enemies = 1'b0; idle = 1'b0;
      end
      if (n == 5) begin
        link_x = 9'($urandom_range(0, 511)); link_y = 8'($urandom_range(0, 255));
        enemy_x = 9'($urandom_range(0, 511)); enemy_y = 8'($urandom_range(0, 255));
      end
      if (vga_plot) begin
        n_plots++;
        if (exp_q.size() == 0) check({tag, "_extra_plot"}, 64'(n), 64'd0);
        else begin
          e = exp_q.pop_front();
          check({tag, "_plot"}, pack_obs(n), pack_exp(e));
        end
      end
      if ((dones() & own) != 4'b0) begin
        done_seen++;
        done_at = n;
      end
      if ((dones() & ~own) != 4'b0) check({tag, "_stray_done"}, 64'(dones()), 64'd0);
    end
    check({tag, "_done_cycle"}, 64'(done_at), 64'(done_cyc));
    check({tag, "_done_count"}, 64'(done_seen), 64'd1);
    check({tag, "_plot_count"}, 64'(n_plots), 64'(exp_plots));
  endtask

  task automatic idle_run(input string tag, input int drop_at);
    @(negedge clock);
    idle = 1'b1;
    @(posedge clock);
    for (int n = 1; n <= 14; n++) begin
      @(negedge clock);
      if (drop_at == 0) check({tag, "_idle_done"}, 64'(idle_done), 64'(n == 10));
      else              check({tag, "_idle_done"}, 64'(idle_done), 64'd0);
      check({tag, "_no_plot"}, 64'(vga_plot), 64'd0);
      if (n == drop_at || n == 10) idle = 1'b0;
    end
  endtask

  initial begin
    int dc, plots, n, x, y;
    plot_t e;

    repeat (3) @(negedge clock);
    check("reset_outputs", all_outputs(), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("post_reset_outputs", all_outputs(), 64'd0);

    idle_run("idle_hold", 0);
    idle_run("idle_abort", 4);
    idle_run("idle_after_abort", 0);

    run_draw("map", J_MAP, 0, 0);
    run_draw("link_edge", J_LINK, 312, 100);
    run_draw("enemy_bottom", J_ENEMY, 0, 232);
    for (int i = 0; i < 6; i++) begin
      x = $urandom_range(0, 335);
      y = $urandom_range(0, 250);
      run_draw((i % 2 == 0) ? "link_rand" : "enemy_rand", (i % 2 == 0) ? J_LINK : J_ENEMY, x, y);
    end
    enemy_sparse = 1'b1;
    run_draw("enemy_keyed", J_ENEMY, 40, 50);
    enemy_sparse = 1'b0;

    // Reset in the middle of a map draw, then restart from the first pixel.
    @(negedge clock);
    draw_map = 1'b1; idle = 1'b1;
    @(posedge clock);
    plots = 0; n = 0;
    while (plots < 1000 && n < 2000) begin
      @(negedge clock);
      n++;
      if (n == 1) begin draw_map = 1'b0; idle = 1'b0; end
      if (vga_plot) plots++;
    end
    check("rst_reached_plot", 64'(plots), 64'd1000);
    reset = 1'b1;
    #1;
    check("rst_outputs_now", all_outputs(), 64'd0);
    repeat (2) @(negedge clock);
    check("rst_outputs_held", all_outputs(), 64'd0);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check("rst_no_done", all_outputs(), 64'd0);
    end
    build_expect(J_MAP, 0, 0, dc);
    draw_map = 1'b1;
    @(posedge clock);
    plots = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clock);
      if (k == 1) draw_map = 1'b0;
      if (vga_plot) begin
        plots++;
        e = exp_q.pop_front();
        check("redraw_plot", pack_obs(k), pack_exp(e));
      end
    end
    check("redraw_plot_count", 64'(plots), 64'd29);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/draw_datapath.md
DRAW_DATAPATH -- requirements
Module: draw_datapath

Interface
REQ-001 Parameter SCREEN_W, default 320, map width in pixels.
REQ-002 Parameter SCREEN_H, default 240, map height in pixels.
REQ-003 Parameter SPRITE, default 16, sprite edge length in pixels.
REQ-004 Parameter FRAME_TICKS, default 833333, clock cycles per idle frame (50 MHz / 60).
REQ-005 clock  in  1  single clock; all logic on posedge clock.
REQ-006 reset  in  1  reset is asynchronous and active-high.
REQ-007 idle, draw_map, draw_link, draw_enemies  in  1 each  level requests from the game controller, held high for the controller state's duration.
REQ-008 link_x, enemy_x  in  9; link_y, enemy_y  in  8  sprite top-left pixel positions.
REQ-009 rom_addr  out  17  graphics ROM address; rom_data  in  9  pixel colour, valid one cycle after its address.
REQ-010 vga_x  out  9; vga_y  out  8; vga_colour  out  9; vga_plot  out  1  pixel write to the VGA adapter.
REQ-011 idle_done, draw_map_done, draw_link_done, draw_enemies_done  out  1 each  one-cycle completion pulses.

Function
REQ-012 FSM states: S_WAIT, S_IDLE_CNT, S_MAP, S_LINK, S_ENEMY, S_DRAIN, S_DONE.
REQ-013 In S_WAIT, a sampled request selects the next state; priority if several are high: draw_map > draw_link > draw_enemies > idle.
REQ-014 S_MAP scans col 0..SCREEN_W-1 inner and row 0..SCREEN_H-1 outer; rom_addr = row*SCREEN_W+col.
REQ-015 S_LINK/S_ENEMY scan 16x16; rom_addr = LINK_BASE (76800) or ENEMY_BASE (77056) + row*16+col.
REQ-016 The sprite position is latched on entry to S_LINK/S_ENEMY; position changes mid-draw are ignored.
REQ-017 One address per cycle starting the cycle after the sampling edge; vga_plot, vga_x, vga_y, vga_colour appear one cycle after the matching address (one-stage pipeline).
REQ-018 Sprite pixels with x >= SCREEN_W or y >= SCREEN_H are clipped: vga_plot stays 0, the slot is still consumed, and there is no x/y wrap-around.
REQ-019 After the last address the FSM passes through S_DRAIN (last plot), then S_DONE, which pulses the matching *_done for exactly one cycle.
REQ-020 S_DONE returns to S_WAIT; a request still high is re-serviced only after passing through S_WAIT.
REQ-021 Map completion: draw_map_done is high exactly 76802 cycles after the sampling edge. Sprite completion: *_done is high exactly 258 cycles after the sampling edge.
REQ-022 S_IDLE_CNT counts FRAME_TICKS cycles, then goes to S_DONE and pulses idle_done.
REQ-023 If idle drops during S_IDLE_CNT, the counter clears and the FSM returns to S_WAIT without idle_done.
REQ-024 A draw request dropping mid-draw does not abort the draw; the draw completes and done still pulses.
REQ-025 vga_plot is 0 outside S_MAP/S_LINK/S_ENEMY/S_DRAIN.

Reset
REQ-026 Reset forces S_WAIT, zeroes all counters and pipeline registers, and drives every output to 0.
REQ-027 Reset mid-operation aborts it immediately with no done pulse; the first request after release restarts from pixel (0,0).

Configuration
REQ-028 With TRANSPARENCY_EN defined, sprite pixels whose rom_data equals 9'h1FF are not plotted (vga_plot 0); map pixels are always plotted.
REQ-029 Without TRANSPARENCY_EN, every in-screen pixel is plotted; timing is identical in both builds.

Structure
REQ-030 Shared package zelda_pkg holds: SCREEN_W/H, SPRITE, LINK_BASE, ENEMY_BASE, TRANSPARENT colour, and the draw state enum.
REQ-031 The idle counter is sub-module frame_timer (inputs enable and clear; output tick pulse).

Verification
REQ-032 FRAME_TICKS=10, idle held high -> idle_done is high exactly 10 cycles after the sampling edge, one cycle wide.
REQ-033 draw_map pulse, ROM model returns addr[8:0] -> 76800 plots in raster order; plot (319,239) is followed by draw_map_done one cycle later.
REQ-034 draw_link with link_x=312, link_y=100 -> only cols 312..319 plotted (128 plots); draw_link_done is still at cycle 258.
REQ-035 TRANSPARENCY_EN, enemy ROM words all 9'h1FF except one 9'h007 at row 3 col 5, enemy at (40,50) -> a single plot at (45,53) colour 9'h007.
REQ-036 draw_map and idle high together -> map drawn first; reset asserted at plot 1000 -> all outputs 0 at once, no done; after release, the redraw starts at (0,0).
